// File: rtl/iob_uart_poll_ctrl_pkg.sv
// Shared types and constants for the polled UART controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iob_uart_poll_ctrl_pkg;

    // Controller states: the five init writes first, then the polling loop.
    typedef enum logic [3:0] {
        S_SRST,
        S_SRST_CLR,
        S_DIV,
        S_TXEN,
        S_RXEN,
        S_IDLE,
        S_POLL_RX,
        S_RD_RX,
        S_POLL_TX,
        S_WR_TX
    } state_t;

    // UART register word addresses
    localparam int unsigned REG_SOFTRESET = 0;
    localparam int unsigned REG_DIV       = 1;
    localparam int unsigned REG_TXDATA    = 2;
    localparam int unsigned REG_TXEN      = 3;
    localparam int unsigned REG_TXREADY   = 4;
    localparam int unsigned REG_RXDATA    = 5;
    localparam int unsigned REG_RXEN      = 6;
    localparam int unsigned REG_RXREADY   = 7;

    // Byte strobes: reads, single-byte writes, 16-bit divisor write
    localparam logic [3:0] WSTRB_READ = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;

    // Round-robin pointer encoding
    localparam logic PRIO_RX = 1'b0;
    localparam logic PRIO_TX = 1'b1;

endpackage

// File: rtl/iob_uart_poll_ctrl_if.sv
// UART register bus between the polling controller (master) and the UART core (slave).
// Latency: n/a (wiring only).
// Backpressure: master holds valid/addr/wdata/wstrb until a cycle with ready.
interface iob_uart_poll_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) ();
    logic              uart_valid;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic [3:0]        uart_wstrb;
    logic [DATA_W-1:0] uart_rdata;
    logic              uart_ready;

    modport master (
        output uart_valid, uart_addr, uart_wdata, uart_wstrb,
        input  uart_rdata, uart_ready
    );

    modport slave (
        input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
        output uart_rdata, uart_ready
    );
endinterface

// File: rtl/iob_uart_byte_buf.sv
// One-entry valid/ready byte register.
// Latency: 1 cycle from accepted input to out_vld_o.
// Backpressure: in_rdy_o low while full; load and drain never share a cycle.
module iob_uart_byte_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld_i,
    input  logic [7:0] in_dat_i,
    output logic       in_rdy_o,
    output logic       out_vld_o,
    output logic [7:0] out_dat_o,
    input  logic       out_rdy_i
);
    logic       full_q, full_d;
    logic [7:0] dat_q, dat_d;

    // Fill only when empty, drain only when full, so the two are exclusive.
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (!full_q && in_vld_i) begin
            full_d = 1'b1;
            dat_d  = in_dat_i;
        end else if (full_q && out_rdy_i) begin
            full_d = 1'b0;
        end
    end

    // Storage register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= 8'h00;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign in_rdy_o  = !full_q;
    assign out_vld_o = full_q;
    assign out_dat_o = dat_q;
endmodule

// File: rtl/iob_uart_poll_ctrl.sv
// Polled UART controller: configures the UART, then moves bytes between tx/rx streams and UART registers.
// Latency: one register access per bus handshake, one dead cycle between accesses.
// Backpressure: tx_ready_o low while the tx byte is pending; polling pauses while rx byte is unread.
// Optional macro UART_POLL_TIMEOUT_EN adds a per-access watchdog that aborts stalled accesses and sets err_o.
module iob_uart_poll_ctrl
    import iob_uart_poll_ctrl_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 3,
    parameter logic [15:0] DIV     = 16'd100,
    parameter int          TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid_i,
    input  logic [7:0]           tx_data_i,
    output logic                 tx_ready_o,
    output logic                 rx_valid_o,
    output logic [7:0]           rx_data_o,
    input  logic                 rx_ready_i,
    iob_uart_poll_ctrl_if.master uart,
    output logic                 init_done_o,
    output logic                 err_o
);
    state_t            state_q, state_d;
    logic              gap_q, gap_d;
    logic              init_done_q, init_done_d;
    logic              prio_q, prio_d;

    logic              bus_vld;
    logic              fire;
    logic              wd_expire;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [3:0]        acc_wstrb;

    logic              tx_in_rdy, tx_full, tx_drain;
    logic [7:0]        tx_dat;
    logic              rx_in_rdy, rx_load;

    iob_uart_byte_buf u_tx_buf (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (tx_valid_i && init_done_q),
        .in_dat_i  (tx_data_i),
        .in_rdy_o  (tx_in_rdy),
        .out_vld_o (tx_full),
        .out_dat_o (tx_dat),
        .out_rdy_i (tx_drain)
    );

    iob_uart_byte_buf u_rx_buf (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (rx_load),
        .in_dat_i  (uart.uart_rdata[7:0]),
        .in_rdy_o  (rx_in_rdy),
        .out_vld_o (rx_valid_o),
        .out_dat_o (rx_data_o),
        .out_rdy_i (rx_ready_i)
    );

    assign tx_ready_o  = init_done_q && tx_in_rdy;
    assign init_done_o = init_done_q;

    // Every state except S_IDLE owns one access; gap_q forces the dead cycle after each one.
    assign bus_vld = (state_q != S_IDLE) && !gap_q;
    assign fire    = bus_vld && uart.uart_ready;

    // Register access owned by the current state.
    always_comb begin
        acc_addr  = '0;
        acc_wdata = '0;
        acc_wstrb = WSTRB_READ;
        case (state_q)
            S_SRST: begin
                acc_addr  = ADDR_W'(REG_SOFTRESET);
                acc_wdata = DATA_W'(1);
                acc_wstrb = WSTRB_BYTE;
            end
            S_SRST_CLR: begin
                acc_addr  = ADDR_W'(REG_SOFTRESET);
                acc_wstrb = WSTRB_BYTE;
            end
            S_DIV: begin
                acc_addr  = ADDR_W'(REG_DIV);
                acc_wdata = DATA_W'(DIV);
                acc_wstrb = WSTRB_HALF;
            end
            S_TXEN: begin
                acc_addr  = ADDR_W'(REG_TXEN);
                acc_wdata = DATA_W'(1);
                acc_wstrb = WSTRB_BYTE;
            end
            S_RXEN: begin
                acc_addr  = ADDR_W'(REG_RXEN);
                acc_wdata = DATA_W'(1);
                acc_wstrb = WSTRB_BYTE;
            end
            S_POLL_RX: acc_addr = ADDR_W'(REG_RXREADY);
            S_RD_RX:   acc_addr = ADDR_W'(REG_RXDATA);
            S_POLL_TX: acc_addr = ADDR_W'(REG_TXREADY);
            S_WR_TX: begin
                acc_addr  = ADDR_W'(REG_TXDATA);
                acc_wdata = DATA_W'(tx_dat);
                acc_wstrb = WSTRB_BYTE;
            end
            default: ;
        endcase
    end

    // Bus outputs are zero whenever no access is being offered.
    assign uart.uart_valid = bus_vld;
    assign uart.uart_addr  = bus_vld ? acc_addr  : '0;
    assign uart.uart_wdata = bus_vld ? acc_wdata : '0;
    assign uart.uart_wstrb = bus_vld ? acc_wstrb : WSTRB_READ;

`ifdef UART_POLL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            unused_rdata;

    // Count stalled cycles of the offered access; restart from zero at every new access.
    always_comb begin
        wd_d      = wd_q;
        err_d     = err_q;
        wd_expire = 1'b0;
        if (!bus_vld || fire) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_d      = '0;
            wd_expire = 1'b1;
            err_d     = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o        = err_q;
    assign unused_rdata = ^uart.uart_rdata[DATA_W-1:8];
`else
    logic unused_rdata;

    assign wd_expire    = 1'b0;
    assign err_o        = 1'b0;
    assign unused_rdata = ^{uart.uart_rdata[DATA_W-1:8], (TIMEOUT != 0)};
`endif

    // Next state: init chain, round-robin arbitration in idle, poll/transfer pairs.
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        prio_d      = prio_q;
        gap_d       = fire || wd_expire;
        rx_load     = 1'b0;
        tx_drain    = 1'b0;
        if (wd_expire) begin
            // Aborted access: buffers untouched; init states retry themselves.
            state_d = init_done_q ? S_IDLE : state_q;
        end else begin
            case (state_q)
                S_SRST:     if (fire) state_d = S_SRST_CLR;
                S_SRST_CLR: if (fire) state_d = S_DIV;
                S_DIV:      if (fire) state_d = S_TXEN;
                S_TXEN:     if (fire) state_d = S_RXEN;
                S_RXEN: begin
                    if (fire) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rx_in_rdy && (!tx_full || prio_q == PRIO_RX)) begin
                        state_d = S_POLL_RX;
                    end else if (tx_full) begin
                        state_d = S_POLL_TX;
                    end
                end
                S_POLL_RX: begin
                    if (fire) begin
                        prio_d  = !prio_q;
                        state_d = uart.uart_rdata[0] ? S_RD_RX : S_IDLE;
                    end
                end
                S_RD_RX: begin
                    if (fire) begin
                        rx_load = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_POLL_TX: begin
                    if (fire) begin
                        prio_d  = !prio_q;
                        state_d = uart.uart_rdata[0] ? S_WR_TX : S_IDLE;
                    end
                end
                S_WR_TX: begin
                    if (fire) begin
                        tx_drain = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_SRST;
            endcase
        end
    end

    // State register; reset restarts the init chain with a dead cycle first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SRST;
            gap_q       <= 1'b1;
            init_done_q <= 1'b0;
            prio_q      <= PRIO_RX;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
            prio_q      <= prio_d;
        end
    end
endmodule

// File: tb/tb_iob_uart_poll_ctrl.sv
// Directed bench for the polled UART controller with a simple UART register model.
// Latency: n/a.
// Backpressure: bus model answers each access one half-cycle after valid rises, or never when hung.
`timescale 1ns/1ps
module tb_iob_uart_poll_ctrl;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       init_done;
    logic       err;

    logic        hang_all;
    logic        hang_wr;
    logic [31:0] txready_reg;
    logic [31:0] rxready_reg;
    logic [31:0] rxdata_reg;
    acc_t        log_q[$];

    int tests;
    int fails;

    iob_uart_poll_ctrl_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    iob_uart_poll_ctrl #(
        .DATA_W  (32),
        .ADDR_W  (3),
        .DIV     (16'd100),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .rx_valid_o  (rx_valid),
        .rx_data_o   (rx_data),
        .rx_ready_i  (rx_ready),
        .uart        (bus),
        .init_done_o (init_done),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    // UART register model: answers at the negedge, logs each accepted access.
    initial begin
        bus.uart_ready = 1'b0;
        bus.uart_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.uart_valid && !bus.uart_ready && !hang_all &&
                !(hang_wr && bus.uart_addr == 3'd2)) begin
                bus.uart_ready = 1'b1;
                case (bus.uart_addr)
                    3'd4: bus.uart_rdata = txready_reg;
                    3'd5: begin
                        bus.uart_rdata = rxdata_reg;
                        rxready_reg    = 32'h0;
                    end
                    3'd7: bus.uart_rdata = rxready_reg;
                    default: bus.uart_rdata = 32'h0;
                endcase
                log_q.push_back(acc_t'{bus.uart_addr, bus.uart_wdata, bus.uart_wstrb});
            end else begin
                bus.uart_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        @(posedge clk);
        log_q.delete();
        @(negedge clk);
    endtask

    function automatic logic [63:0] acc(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        return {25'd0, a, d, s};
    endfunction

    function automatic logic [63:0] ent(input int i);
        if (i < log_q.size()) return {25'd0, log_q[i]};
        return 64'hDEAD;
    endfunction

    function automatic int count_addr(input logic [2:0] a);
        int c = 0;
        foreach (log_q[i]) if (log_q[i].addr == a) c++;
        return c;
    endfunction

    initial begin
        int   n;
        int   viol;
        acc_t other[$];

        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        rx_ready    = 1'b0;
        hang_all    = 1'b0;
        hang_wr     = 1'b0;
        txready_reg = 32'h0;
        rxready_reg = 32'h0;
        rxdata_reg  = 32'h0;

        // Reset state
        cyc(3);
        chk("rst_valid", bus.uart_valid, 1'b0);
        chk("rst_addr", bus.uart_addr, 3'd0);
        chk("rst_wdata", bus.uart_wdata, 32'h0);
        chk("rst_wstrb", bus.uart_wstrb, 4'h0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_err", err, 1'b0);

        // First access right after reset release
        rst = 1'b0;
        @(negedge clk);
        chk("first_valid", bus.uart_valid, 1'b1);
        chk("first_acc", {25'd0, bus.uart_addr, bus.uart_wdata, bus.uart_wstrb}, acc(3'd0, 32'd1, 4'b0001));

        // Init write sequence
        n = 0;
        while (!init_done && n < 100) begin @(negedge clk); n++; end
        chk("init_done", init_done, 1'b1);
        chk("init_acc0", ent(0), acc(3'd0, 32'd1, 4'b0001));
        chk("init_acc1", ent(1), acc(3'd0, 32'd0, 4'b0001));
        chk("init_acc2", ent(2), acc(3'd1, 32'd100, 4'b0011));
        chk("init_acc3", ent(3), acc(3'd3, 32'd1, 4'b0001));
        chk("init_acc4", ent(4), acc(3'd6, 32'd1, 4'b0001));
        chk("tx_ready_after_init", tx_ready, 1'b1);

        // TX byte 0x41 with TXREADY=1
        clear_log();
        txready_reg = 32'h1;
        tx_data     = 8'h41;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_full", tx_ready, 1'b0);
        n = 0;
        while (!tx_ready && n < 40) begin @(negedge clk); n++; end
        chk("tx_ready_back", tx_ready, 1'b1);
        other.delete();
        foreach (log_q[i]) if (log_q[i].addr != 3'd7) other.push_back(log_q[i]);
        chk("tx_nacc", other.size(), 2);
        if (other.size() == 2) begin
            chk("tx_poll", {25'd0, other[0]}, acc(3'd4, 32'h0, 4'b0000));
            chk("tx_write", {25'd0, other[1]}, acc(3'd2, 32'h41, 4'b0001));
        end

        // RX byte 0x5A (upper rdata bits must be ignored), consumer stalled
        rxdata_reg  = 32'hFFFF_FF5A;
        rxready_reg = 32'h1;
        n = 0;
        while (!rx_valid && n < 40) begin @(negedge clk); n++; end
        chk("rx_valid", rx_valid, 1'b1);
        chk("rx_data", rx_data, 8'h5A);
        clear_log();
        cyc(20);
        chk("rx_full_no_poll", log_q.size(), 0);
        chk("rx_hold", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_drained", rx_valid, 1'b0);
        clear_log();
        cyc(10);
        chk("rx_repoll", count_addr(3'd7) > 0, 1'b1);

        // Both eligible, both status registers 0: polls must alternate
        txready_reg = 32'h0;
        chk("tx_ready_pre_alt", tx_ready, 1'b1);
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc(6);
        clear_log();
        cyc(20);
        viol = 0;
        foreach (log_q[i]) begin
            if (!(log_q[i].addr inside {3'd4, 3'd7})) viol++;
            if (i > 0 && log_q[i].addr == log_q[i-1].addr) viol++;
        end
        chk("alt_violations", viol, 0);
        chk("alt_enough", log_q.size() >= 8, 1'b1);

        // Reset in the middle of a stalled TXDATA write
        hang_wr     = 1'b1;
        txready_reg = 32'h1;
        n = 0;
        while (!(bus.uart_valid && bus.uart_addr == 3'd2) && n < 40) begin @(negedge clk); n++; end
        chk("wrtx_seen", {bus.uart_valid, bus.uart_addr, bus.uart_wdata}, {1'b1, 3'd2, 32'h33});
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", bus.uart_valid, 1'b0);
        chk("midrst_bus", {bus.uart_addr, bus.uart_wdata, bus.uart_wstrb}, 39'd0);
        chk("midrst_tx_ready", tx_ready, 1'b0);
        chk("midrst_init_done", init_done, 1'b0);
        hang_wr = 1'b0;
        clear_log();
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 100) begin @(negedge clk); n++; end
        chk("reinit_done", init_done, 1'b1);
        chk("reinit_acc0", ent(0), acc(3'd0, 32'd1, 4'b0001));
        chk("reinit_acc4", ent(4), acc(3'd6, 32'd1, 4'b0001));
        cyc(10);
        chk("reinit_tx_empty", count_addr(3'd4) + count_addr(3'd2), 0);
        chk("reinit_tx_ready", tx_ready, 1'b1);

`ifdef UART_POLL_TIMEOUT_EN
        // Bus never answers: access dropped after 8 cycles, err sticky
        rst      = 1'b1;
        hang_all = 1'b1;
        cyc(2);
        chk("to_err_rst", err, 1'b0);
        rst = 1'b0;
        n = 0;
        while (!bus.uart_valid && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (bus.uart_valid && n < 30) begin n++; @(negedge clk); end
        chk("to_valid_cycles", n, 8);
        chk("to_err", err, 1'b1);
        cyc(30);
        chk("to_err_sticky", err, 1'b1);
        chk("to_no_init", init_done, 1'b0);
`else
        chk("err_tied", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
